page_table_ram: RTL and testbench
=================================

Name: page_table_ram

Overview:
- Page table storage that sits directly upstream of the RAM MMU.
- Combinationally supplies the page table entry for the index the MMU computes (page number plus page table base). Accepts single-entry writes from the execution unit.
- Runs a sequencer that invalidates the whole table after reset, or one 32-entry process table on request (process exit or teardown).
- Entry format: bit 15 = page assigned, bit 14 = read-only, bits 6:0 = physical page; other bits stored, not interpreted.

Parameters:
- ENTRIES, 512, number of page table entries; must be 2^ADDR_W.
- ADDR_W, 9, entry index width.
- DATA_W, 16, entry width.
- PROC_PAGES, 32, entries per process table (one per 2 KiB page of a 64 KiB space).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  ADDR_W  entry index from MMU
- rd_data  out  DATA_W  entry to MMU
- wr_en  in  1  single-entry write strobe from execution unit
- wr_addr  in  ADDR_W  write index
- wr_data  in  DATA_W  write data
- wr_reject  out  1  one-cycle pulse: wr_en was dropped because busy
- clr_start  in  1  request to invalidate one process table
- clr_base  in  ADDR_W  first index of table to clear (low 9 bits of ptb)
- busy  out  1  sequencer active (INIT or CLEAR)
- clr_done  out  1  one-cycle pulse when a CLEAR completes

Behaviour:
- One clock; reset is asynchronous and active-low.
- Storage is a register array. Writes take effect at the clock edge. Reads are combinational: rd_data = array[rd_addr], except that rd_data = 0 while in INIT.
- A read in the same cycle as a write to the same index returns the old value; the new value is visible the next cycle.
- Reset (rst_n low): state = INIT, cnt = 0, busy = 1, wr_reject = 0, clr_done = 0. Array contents are not reset directly.
- INIT: each edge writes 0 to array[cnt] and increments cnt. After the write of index ENTRIES-1 (512 edges after reset release), state goes to IDLE and busy drops to 0. No clr_done pulse on INIT completion.
- IDLE:
  - wr_en = 1 writes array[wr_addr] = wr_data.
  - clr_start = 1 latches base = clr_base, sets cnt = 0, enters CLEAR, and raises busy on the next cycle.
- CLEAR: each edge writes 0 to array[(base + cnt) mod ENTRIES] and increments cnt. Wrap-around past index 511 goes to index 0 (9-bit add, carry discarded).
  - After the write at cnt = PROC_PAGES-1 (32 edges after entry), state goes to IDLE, busy = 0, and clr_done = 1 for exactly one cycle.
  - Reads in CLEAR return current array contents: already-cleared entries read 0, remaining entries read their old value.
- wr_en and clr_start high in the same IDLE cycle: the write is performed, then CLEAR starts. If the written index is in range, CLEAR later overwrites it with 0.
- wr_en while busy (INIT or CLEAR): no write; wr_reject = 1 on the following cycle for one cycle, once per rejected request cycle.
- clr_start while busy: ignored, no latch, no pulse.
- rst_n asserted mid-INIT or mid-CLEAR: the sequence aborts immediately and INIT restarts from index 0 after release.
- All outputs are registered except rd_data.

Test Plan:
- Reset release -> busy = 1 for 512 cycles; rd_addr = 0x005 reads 0x0000 throughout. Afterwards busy = 0, all 512 entries read 0x0000, no clr_done pulse.
- Idle write wr_addr = 0x0A3, wr_data = 0xC012 -> rd_addr = 0x0A3 reads the old value (0x0000) in the write cycle and 0xC012 the next cycle. Indices 0x0A2 and 0x0A4 are unchanged.
- Fill 0x040..0x05F with 0x8000|i, pulse clr_start with clr_base = 0x040 -> busy high 32 cycles, then clr_done one-cycle pulse. 0x040..0x05F read 0x0000; 0x03F and 0x060 keep their data.
- clr_base = 0x1F0 with all entries 0xFFFF -> entries 0x1F0..0x1FF and 0x000..0x00F read 0x0000 (wrap), 0x010 and 0x1EF read 0xFFFF.
- wr_en at 0x041 during CLEAR -> no write, wr_reject pulses the next cycle. wr_en and clr_start simultaneous at 0x045 inside range -> entry ends at 0x0000.
- rst_n low at CLEAR count 10 -> busy stays 1, INIT reruns for 512 cycles, no clr_done, all entries read 0x0000 after.

Source files
------------

// File: rtl/page_table_ram.sv
// Page table storage for the RAM MMU: combinational entry lookup, single-entry
// writes, and a sequencer that zeroes the whole table after reset or one process table.
module page_table_ram #(
  parameter int ENTRIES    = 512,
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 16,
  parameter int PROC_PAGES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_reject,
  input  logic              clr_start,
  input  logic [ADDR_W-1:0] clr_base,
  output logic              busy,
  output logic              clr_done
);

  // Handshake: wr_en and clr_start are single-cycle requests sampled every edge.
  // They are accepted only while busy is low; a dropped write is reported by a
  // one-cycle wr_reject pulse one cycle later, a dropped clr_start is silent.

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_CLEAR} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(ENTRIES - 1);
  localparam logic [ADDR_W-1:0] LAST_CLR = ADDR_W'(PROC_PAGES - 1);

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] base;
  logic [DATA_W-1:0] mem [ENTRIES];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [DATA_W-1:0] mem_wd;

  // Single write port shared by the execution unit and the sequencer.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = cnt;
    mem_wd = '0;
    unique case (state)
      ST_INIT:  mem_we = rst_n;
      ST_IDLE: begin
        mem_we = wr_en && rst_n;
        mem_wa = wr_addr;
        mem_wd = wr_data;
      end
      ST_CLEAR: begin
        mem_we = rst_n;
        mem_wa = base + cnt;
      end
      default: mem_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign rd_data = (state == ST_INIT) ? '0 : mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      cnt       <= '0;
      base      <= '0;
      busy      <= 1'b1;
      wr_reject <= 1'b0;
      clr_done  <= 1'b0;
    end else begin
      wr_reject <= wr_en && (state != ST_IDLE);
      clr_done  <= 1'b0;
      unique case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_IDX) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
        end
        ST_IDLE: begin
          if (clr_start) begin
            base  <= clr_base;
            cnt   <= '0;
            state <= ST_CLEAR;
            busy  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CLR) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            clr_done <= 1'b1;
            cnt      <= '0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_page_table_ram.sv
// Bench for page_table_ram: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_page_table_ram;

  localparam int ENTRIES = 512;
  localparam int ADDR_W  = 9;
  localparam int DATA_W  = 16;
  localparam int PROC_PAGES = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_reject;
  logic              clr_start;
  logic [ADDR_W-1:0] clr_base;
  logic              busy;
  logic              clr_done;

  int n_vec = 0;
  int n_err = 0;

  page_table_ram #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .PROC_PAGES(PROC_PAGES)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_reject(wr_reject),
    .clr_start(clr_start), .clr_base(clr_base), .busy(busy), .clr_done(clr_done)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // reference model: pending zero-writes are a queue of indices; busy = queue non-empty
  logic [DATA_W-1:0] exp_mem [ENTRIES];
  int                exp_q[$];
  bit                m_init;
  bit                m_wr_reject;
  bit                m_clr_done;

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < ENTRIES; i++) exp_q.push_back(i);
    m_init      = 1'b1;
    m_wr_reject = 1'b0;
    m_clr_done  = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_wr_reject = wr_en && (exp_q.size() != 0);
      m_clr_done  = 1'b0;
      if (exp_q.size() == 0) begin
        if (wr_en) exp_mem[int'(wr_addr)] = wr_data;
        if (clr_start)
          for (int i = 0; i < PROC_PAGES; i++) exp_q.push_back((int'(clr_base) + i) % ENTRIES);
      end else begin
        exp_mem[exp_q.pop_front()] = '0;
        if (exp_q.size() == 0) begin
          if (!m_init) m_clr_done = 1'b1;
          m_init = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, every cycle mid-period
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("rd_data",   rd_data, m_init ? 16'h0 : exp_mem[int'(rd_addr)]);
      check("busy",      16'(busy),      16'(exp_q.size() != 0));
      check("wr_reject", 16'(wr_reject), 16'(m_wr_reject));
      check("clr_done",  16'(clr_done),  16'(m_clr_done));
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [DATA_W-1:0] d);
    wr_en = 1'b1; wr_addr = ADDR_W'(a); wr_data = d;
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic do_clear(input int b);
    clr_start = 1'b1; clr_base = ADDR_W'(b);
    cyc();
    clr_start = 1'b0;
  endtask

  // counts mid-period samples with busy high; returns at the first idle sample
  task automatic count_busy(output int n, output int dones);
    n = 0; dones = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (clr_done) dones++;
      if (!busy) break;
      n++;
    end
    if (busy) begin
      n_err++;
      $display("FAIL busy_timeout: busy still high after 1000 cycles");
    end
    cyc();
  endtask

  task automatic peek(input string name, input int a, input logic [DATA_W-1:0] exp);
    rd_addr = ADDR_W'(a);
    @(negedge clk);
    check(name, rd_data, exp);
    cyc();
  endtask

  int nb, nd;

  initial begin
    rst_n = 1'b0; rd_addr = 9'h005; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    clr_start = 1'b0; clr_base = '0;
    chk_en = 1'b1;
    repeat (3) cyc();
    check("reset_busy",      16'(busy), 16'h1);
    check("reset_wr_reject", 16'(wr_reject), 16'h0);
    check("reset_clr_done",  16'(clr_done), 16'h0);
    check("reset_rd_data",   rd_data, 16'h0);

    // INIT after reset release
    rst_n = 1'b1;
    count_busy(nb, nd);
    check("init_busy_cycles", 16'(nb), 16'd512);
    check("init_no_done",     16'(nd), 16'd0);
    for (int i = 0; i < ENTRIES; i++) begin rd_addr = ADDR_W'(i); cyc(); end

    // idle write, read-old-during-write
    rd_addr = 9'h0A3;
    wr_en = 1'b1; wr_addr = 9'h0A3; wr_data = 16'hC012;
    @(negedge clk);
    check("wr_same_cycle_old", rd_data, 16'h0000);
    cyc();
    wr_en = 1'b0;
    @(negedge clk);
    check("wr_next_cycle_new", rd_data, 16'hC012);
    cyc();
    peek("wr_neigh_lo", 9'h0A2, 16'h0000);
    peek("wr_neigh_hi", 9'h0A4, 16'h0000);

    // process table clear
    for (int i = 'h40; i <= 'h5F; i++) do_write(i, 16'h8000 | 16'(i));
    do_write('h3F, 16'h1234);
    do_write('h60, 16'h5678);
    peek("fill_check", 'h45, 16'h8045);
    do_clear('h40);
    count_busy(nb, nd);
    check("clr_busy_cycles", 16'(nb), 16'd32);
    check("clr_done_once",   16'(nd), 16'd1);
    @(negedge clk);
    check("clr_done_drops", 16'(clr_done), 16'h0);
    cyc();
    peek("clr_first", 'h40, 16'h0000);
    peek("clr_last",  'h5F, 16'h0000);
    peek("clr_below", 'h3F, 16'h1234);
    peek("clr_above", 'h60, 16'h5678);

    // wrap-around clear
    for (int i = 0; i < ENTRIES; i++) do_write(i, 16'hFFFF);
    do_clear('h1F0);
    count_busy(nb, nd);
    peek("wrap_1f0", 'h1F0, 16'h0000);
    peek("wrap_1ff", 'h1FF, 16'h0000);
    peek("wrap_000", 'h000, 16'h0000);
    peek("wrap_00f", 'h00F, 16'h0000);
    peek("wrap_010", 'h010, 16'hFFFF);
    peek("wrap_1ef", 'h1EF, 16'hFFFF);

    // write rejected during CLEAR
    do_clear('h40);
    do_write('h41, 16'h1111);
    @(negedge clk);
    check("reject_pulse", 16'(wr_reject), 16'h1);
    cyc();
    @(negedge clk);
    check("reject_one_cycle", 16'(wr_reject), 16'h0);
    count_busy(nb, nd);
    peek("reject_no_write", 'h41, 16'h0000);

    // simultaneous write and clear start inside range
    do_write('h45, 16'hABCD);
    wr_en = 1'b1; wr_addr = 9'h045; wr_data = 16'h1357;
    clr_start = 1'b1; clr_base = 9'h040;
    cyc();
    wr_en = 1'b0; clr_start = 1'b0;
    count_busy(nb, nd);
    peek("simul_cleared", 'h45, 16'h0000);

    // reset during CLEAR aborts and reruns INIT
    do_write('h70, 16'h7777);
    do_clear('h60);
    repeat (10) cyc();
    rst_n = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1;
    count_busy(nb, nd);
    check("rst_init_cycles", 16'(nb), 16'd512);
    check("rst_no_done",     16'(nd), 16'd0);
    peek("rst_cleared", 'h70, 16'h0000);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rd_addr   = ADDR_W'($urandom_range(0, ENTRIES - 1));
      wr_en     = ($urandom_range(0, 9) < 4);
      wr_addr   = ($urandom_range(0, 3) == 0) ? rd_addr : ADDR_W'($urandom_range(0, ENTRIES - 1));
      wr_data   = DATA_W'($urandom);
      clr_start = ($urandom_range(0, 49) == 0);
      clr_base  = ADDR_W'($urandom_range(0, ENTRIES - 1));
      cyc();
    end
    wr_en = 1'b0; clr_start = 1'b0;
    count_busy(nb, nd);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
